multicycle_seq: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the write-enable strobes for PC, IR, register file and DMEM, so that the datapath's single-port memory and ALU are reused across cycles. It also provides run/single-step/halt control and cycle and instret counters for the testbench and debug.

---
 rtl/multicycle_seq_if.sv | 32 +++
 rtl/multicycle_seq.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// Control/status bundle between the multi-cycle sequencer and its host
// (datapath glue, testbench or debug logic).
interface multicycle_seq_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run;
  logic             step_req;
  logic [6:0]       opcode;
  logic             ir_we;
  logic             pc_we;
  logic             reg_we;
  logic             dmem_re;
  logic             dmem_we;
  logic             retire;
  logic             halted;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    output run, step_req, opcode,
    input  ir_we, pc_we, reg_we, dmem_re, dmem_we, retire,
    input  halted, illegal, state, cycle_cnt, instret_cnt
  );

  modport slave (
    input  run, step_req, opcode,
    output ir_we, pc_we, reg_we, dmem_re, dmem_we, retire,
    output halted, illegal, state, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping,
// Moore-decoded datapath strobes, run/step/halt control and perf counters.
module multicycle_seq #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_JUMP,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_SYSTEM,
    C_ILLEGAL
  } cls_t;

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic             pend_q, pend_d;
  logic [3:0]       mem_cnt_q, mem_cnt_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  logic ir_we, pc_we, reg_we, dmem_re, dmem_we, retire;
  logic boundary;
  logic mem_last;
  logic busy;

  function automatic cls_t decode_cls(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: decode_cls = C_ALU;
      7'b1101111, 7'b1100111:                         decode_cls = C_JUMP;
      7'b0000011:                                     decode_cls = C_LOAD;
      7'b0100011:                                     decode_cls = C_STORE;
      7'b1100011:                                     decode_cls = C_BRANCH;
      7'b1110011:                                     decode_cls = C_SYSTEM;
      default:                                        decode_cls = C_ILLEGAL;
    endcase
  endfunction

  assign mem_last = (mem_cnt_q == MEM_LAST);
  assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC)  || (state_q == S_MEM)    ||
                    (state_q == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU;
      pend_q    <= 1'b0;
      mem_cnt_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pend_q    <= pend_d;
      mem_cnt_q <= mem_cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes depend only on registered state/class/mem count; run and
  // step_req affect nothing but the next-state choice.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    pend_d    = pend_q;
    mem_cnt_d = mem_cnt_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    boundary  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run || bus.step_req) state_d = S_FETCH;
        if (bus.step_req)            pend_d  = 1'b1;
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cls_d = decode_cls(bus.opcode);
        case (decode_cls(bus.opcode))
          C_SYSTEM: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          C_ILLEGAL: begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD: begin
            dmem_re   = 1'b1;
            state_d   = S_MEM;
            mem_cnt_d = '0;
          end
          C_STORE: begin
            state_d   = S_MEM;
            mem_cnt_d = '0;
          end
          C_BRANCH: begin
            pc_we    = 1'b1;
            retire   = 1'b1;
            boundary = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls_q == C_LOAD) dmem_re = 1'b1;
        if (mem_last) begin
          if (cls_q == C_STORE) begin
            dmem_we  = 1'b1;
            pc_we    = 1'b1;
            retire   = 1'b1;
            boundary = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else begin
          mem_cnt_d = mem_cnt_q + 4'd1;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        retire   = 1'b1;
        boundary = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // A pending single step wins over run so a step always parks in IDLE.
    if (boundary) begin
      if (pend_q) begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end else if (bus.run) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (busy)   cycle_q   <= cycle_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.reg_we      = reg_we;
  assign bus.dmem_re     = dmem_re;
  assign bus.dmem_we     = dmem_we;
  assign bus.retire      = retire;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.state       = state_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !(dmem_re && dmem_we) && !(reg_we && dmem_we));

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed table-driven bench for multicycle_seq plus hand-written
// sequences for reset-during-MEM and counter wrap.
module tb_multicycle_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  multicycle_seq_if #(.CNT_W(32)) bus_a();
  multicycle_seq_if #(.CNT_W(4))  bus_b();

  multicycle_seq #(.MEM_LAT(3), .CNT_W(32)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  multicycle_seq #(.MEM_LAT(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  localparam logic [6:0] OP_ALU = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // strobe vector order: {ir_we, pc_we, reg_we, dmem_re, dmem_we, retire}
  localparam logic [5:0] NO  = 6'b000000;
  localparam logic [5:0] IR  = 6'b100000;
  localparam logic [5:0] WB  = 6'b011001;
  localparam logic [5:0] RE  = 6'b000100;
  localparam logic [5:0] STW = 6'b010011;
  localparam logic [5:0] BR  = 6'b010001;

  typedef struct {
    logic       rst;
    logic       run;
    logic       step;
    logic [6:0] opc;
    logic [2:0] st;
    logic [5:0] strb;
    logic       hlt;
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic rn, input logic s, input logic [6:0] o,
                     input logic [2:0] st, input logic [5:0] sb, input logic h, input logic il);
    vec_t v;
    v.rst = r; v.run = rn; v.step = s; v.opc = o;
    v.st = st; v.strb = sb; v.hlt = h; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] strb_a();
    return {bus_a.ir_we, bus_a.pc_we, bus_a.reg_we, bus_a.dmem_re, bus_a.dmem_we, bus_a.retire};
  endfunction

  function automatic logic [5:0] strb_b();
    return {bus_b.ir_we, bus_b.pc_we, bus_b.reg_we, bus_b.dmem_re, bus_b.dmem_we, bus_b.retire};
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      rst_a          = vecs[i].rst;
      bus_a.run      = vecs[i].run;
      bus_a.step_req = vecs[i].step;
      bus_a.opcode   = vecs[i].opc;
      #1;
      check($sformatf("vec%0d state", i),   32'(bus_a.state),   32'(vecs[i].st));
      check($sformatf("vec%0d strobes", i), 32'(strb_a()),      32'(vecs[i].strb));
      check($sformatf("vec%0d halted", i),  32'(bus_a.halted),  32'(vecs[i].hlt));
      check($sformatf("vec%0d illegal", i), 32'(bus_a.illegal), 32'(vecs[i].ill));
    end
  endtask

  int m_alu, m_ld, m_st, m_step, m_halt, m_rst, m_ill;
  int nret;
  logic found;

  initial begin
    rst_a = 1'b1; bus_a.run = 1'b0; bus_a.step_req = 1'b0; bus_a.opcode = OP_ALU;
    rst_b = 1'b1; bus_b.run = 1'b0; bus_b.step_req = 1'b0; bus_b.opcode = OP_ALU;

    // reset row + three ALU instructions, run dropped during the last WB
    add(1,0,0,OP_ALU, 0,NO,0,0);
    for (int n = 0; n < 3; n++) begin
      add(0,1,0,OP_ALU, (n == 0) ? 3'd0 : 3'd1, (n == 0) ? NO : IR, 0,0);
      if (n == 0) add(0,1,0,OP_ALU, 1,IR,0,0);
      add(0,1,0,OP_ALU, 2,NO,0,0);
      add(0,1,0,OP_ALU, 3,NO,0,0);
      add(0,(n == 2) ? 1'b0 : 1'b1,0,OP_ALU, 5,WB,0,0);
    end
    add(0,0,0,OP_ALU, 0,NO,0,0);
    m_alu = vecs.size();
    // load, MEM_LAT=3
    add(0,1,0,OP_LD, 0,NO,0,0);
    add(0,1,0,OP_LD, 1,IR,0,0);
    add(0,1,0,OP_LD, 2,NO,0,0);
    add(0,1,0,OP_LD, 3,RE,0,0);
    add(0,1,0,OP_LD, 4,RE,0,0);
    add(0,1,0,OP_LD, 4,RE,0,0);
    add(0,1,0,OP_LD, 4,RE,0,0);
    add(0,0,0,OP_LD, 5,WB,0,0);
    add(0,0,0,OP_LD, 0,NO,0,0);
    m_ld = vecs.size();
    // store, MEM_LAT=3
    add(0,1,0,OP_ST, 0,NO,0,0);
    add(0,1,0,OP_ST, 1,IR,0,0);
    add(0,1,0,OP_ST, 2,NO,0,0);
    add(0,1,0,OP_ST, 3,NO,0,0);
    add(0,1,0,OP_ST, 4,NO,0,0);
    add(0,1,0,OP_ST, 4,NO,0,0);
    add(0,0,0,OP_ST, 4,STW,0,0);
    add(0,0,0,OP_ST, 0,NO,0,0);
    m_st = vecs.size();
    // single step of a branch; second step pulse during EXEC is ignored
    add(0,0,1,OP_BR, 0,NO,0,0);
    add(0,0,0,OP_BR, 1,IR,0,0);
    add(0,0,0,OP_BR, 2,NO,0,0);
    add(0,0,1,OP_BR, 3,BR,0,0);
    add(0,0,0,OP_BR, 0,NO,0,0);
    add(0,0,0,OP_BR, 0,NO,0,0);
    m_step = vecs.size();
    // SYSTEM halts
    add(0,1,0,OP_SYS, 0,NO,0,0);
    add(0,1,0,OP_SYS, 1,IR,0,0);
    add(0,1,0,OP_SYS, 2,NO,0,0);
    add(0,1,0,OP_SYS, 6,NO,1,0);
    add(0,1,1,OP_SYS, 6,NO,1,0);
    m_halt = vecs.size();
    // one-cycle reset out of HALT
    add(1,0,0,OP_SYS, 6,NO,1,0);
    add(0,0,0,OP_SYS, 0,NO,0,0);
    m_rst = vecs.size();
    // illegal opcode
    add(0,1,0,OP_BAD, 0,NO,0,0);
    add(0,1,0,OP_BAD, 1,IR,0,0);
    add(0,1,0,OP_BAD, 2,NO,0,0);
    add(0,0,0,OP_BAD, 6,NO,1,1);
    add(0,0,0,OP_BAD, 6,NO,1,1);
    m_ill = vecs.size();

    repeat (2) @(posedge clk);

    run_vecs(0, 1);
    check("reset cycle_cnt",   bus_a.cycle_cnt,   32'd0);
    check("reset instret_cnt", bus_a.instret_cnt, 32'd0);
    run_vecs(1, m_alu);
    check("alu cycle_cnt",   bus_a.cycle_cnt,   32'd12);
    check("alu instret_cnt", bus_a.instret_cnt, 32'd3);
    run_vecs(m_alu, m_ld);
    check("load cycle_cnt",   bus_a.cycle_cnt,   32'd19);
    check("load instret_cnt", bus_a.instret_cnt, 32'd4);
    run_vecs(m_ld, m_st);
    check("store cycle_cnt",   bus_a.cycle_cnt,   32'd25);
    check("store instret_cnt", bus_a.instret_cnt, 32'd5);
    run_vecs(m_st, m_step);
    check("step cycle_cnt",   bus_a.cycle_cnt,   32'd28);
    check("step instret_cnt", bus_a.instret_cnt, 32'd6);
    run_vecs(m_step, m_halt);
    check("halt cycle_cnt",   bus_a.cycle_cnt,   32'd30);
    check("halt instret_cnt", bus_a.instret_cnt, 32'd6);
    run_vecs(m_halt, m_rst);
    check("rst cycle_cnt",   bus_a.cycle_cnt,   32'd0);
    check("rst instret_cnt", bus_a.instret_cnt, 32'd0);
    run_vecs(m_rst, m_ill);
    check("illegal cycle_cnt",   bus_a.cycle_cnt,   32'd2);
    check("illegal instret_cnt", bus_a.instret_cnt, 32'd0);

    // reset during MEM of a load (MEM_LAT=2)
    @(negedge clk);
    rst_b = 1'b0; bus_b.run = 1'b1; bus_b.opcode = OP_LD;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (bus_b.state == 3'd4) found = 1'b1;
    end
    check("b reached MEM", 32'(found), 32'd1);
    check("b MEM dmem_re", 32'(bus_b.dmem_re), 32'd1);
    rst_b = 1'b1; bus_b.run = 1'b0;
    @(negedge clk); #1;
    check("b rst-in-MEM state",   32'(bus_b.state),       32'd0);
    check("b rst-in-MEM strobes", 32'(strb_b()),          32'd0);
    check("b rst-in-MEM instret", 32'(bus_b.instret_cnt), 32'd0);
    check("b rst-in-MEM cycles",  32'(bus_b.cycle_cnt),   32'd0);
    rst_b = 1'b0;
    @(negedge clk); #1;
    check("b idle after rst", 32'(bus_b.state), 32'd0);

    // 17 ALU instructions with 4-bit counters
    bus_b.opcode = OP_ALU; bus_b.run = 1'b1;
    nret = 0;
    for (int k = 0; k < 300 && nret < 17; k++) begin
      @(negedge clk); #1;
      if (bus_b.retire) begin
        nret++;
        if (nret == 17) bus_b.run = 1'b0;
      end
    end
    check("b retire count", 32'(nret), 32'd17);
    @(negedge clk); #1;
    check("b wrap state",   32'(bus_b.state),       32'd0);
    check("b wrap instret", 32'(bus_b.instret_cnt), 32'd1);
    check("b wrap cycles",  32'(bus_b.cycle_cnt),   32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
